// File: rtl/cdc_pkg.sv
// Shared definitions for the CDC handshake sender slice.
// Holds the handshake FSM state type and the default payload width,
// FIFO depth and acknowledge timeout used by cdc_handshake_sender.
package cdc_pkg;

  localparam int CDC_WIDTH   = 4;
  localparam int CDC_DEPTH   = 4;
  localparam int CDC_TIMEOUT = 255;

  // IDLE: nothing outstanding. WAIT_ACK: a word is on s_data awaiting s_ack.
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } cdc_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO feeding the handshake sender.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, din    - write request and data (ignored while full)
//   pop          - read request (ignored while empty)
//   dout         - head entry, valid whenever empty is 0
//   full, empty  - registered status flags
// Pointers carry one extra bit above the address so that equal addresses
// can be told apart as either empty (same wrap) or full (opposite wrap).
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      wr_ptr_nxt_s;
  logic [AW:0]      rd_ptr_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             full_nxt_s;
  logic             empty_nxt_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests against the current flags and derive next pointers/flags.
  always_comb begin
    push_ok_s    = push & ~full_r;
    pop_ok_s     = pop & ~empty_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (push_ok_s) begin
      wr_ptr_nxt_s = wr_ptr_r + (AW+1)'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_ok_s) begin
      rd_ptr_nxt_s = rd_ptr_r + (AW+1)'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    full_nxt_s  = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                  (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
  end

  // Pointer and flag registers; flags are precomputed so they come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      full_r   <= full_nxt_s;
      empty_r  <= empty_nxt_s;
    end
  end

  // Storage array; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r[AW-1:0]];
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/cdc_handshake_sender.sv
// Sender side of a pulse/acknowledge clock-domain-crossing handshake.
// Words are queued in a small FIFO, then launched one at a time: the head
// is loaded into s_data with a one-cycle s_en pulse, and s_data is held
// until s_ack returns. A wait counter flags a missing acknowledge.
// Ports:
//   clk, rst_n          - sender clock, asynchronous active-low reset
//   up_valid/up_data    - upstream word offer
//   up_ready            - upstream word accepted this cycle (FIFO not full)
//   s_en, s_data        - send pulse and payload toward the other domain
//   s_ack               - acknowledge pulse, already synchronised to clk
//   busy                - a transfer is outstanding
//   timeout_err         - sticky: no acknowledge within TIMEOUT cycles
//   spurious_ack        - sticky: s_ack arrived with nothing outstanding
//   sent_count          - acknowledged transfers, wrapping at 2^16
module cdc_handshake_sender
  import cdc_pkg::*;
#(
  parameter int WIDTH   = CDC_WIDTH,
  parameter int DEPTH   = CDC_DEPTH,
  parameter int TIMEOUT = CDC_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             s_en,
  output logic [WIDTH-1:0] s_data,
  input  logic             s_ack,
  output logic             busy,
  output logic             timeout_err,
  output logic             spurious_ack,
  output logic [15:0]      sent_count
);

  localparam int              CW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TIMEOUT_C = CW'(TIMEOUT);

  cdc_state_e       state_r;
  cdc_state_e       state_nxt_s;
  logic [CW-1:0]    wait_cnt_r;
  logic [CW-1:0]    wait_cnt_nxt_s;
  logic             s_en_r;
  logic [WIDTH-1:0] s_data_r;
  logic             timeout_err_r;
  logic             spurious_ack_r;
  logic [15:0]      sent_count_r;

  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [WIDTH-1:0] fifo_dout_s;
  logic             push_s;
  logic             pop_s;
  logic             ack_ok_s;
  logic             timeout_hit_s;
  logic             spurious_s;

  assign up_ready = ~fifo_full_s;
  assign push_s   = up_valid & ~fifo_full_s;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (up_data),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Handshake FSM next state, FIFO pop, wait counter and flag events.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    pop_s          = 1'b0;
    ack_ok_s       = 1'b0;
    timeout_hit_s  = 1'b0;
    spurious_s     = 1'b0;
    case (state_r)
      IDLE: begin
        // An ack here has nothing to complete; only the flag records it.
        spurious_s = s_ack;
        if (!fifo_empty_s) begin
          pop_s          = 1'b1;
          state_nxt_s    = WAIT_ACK;
          wait_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_ACK: begin
        if (s_ack) begin
          ack_ok_s    = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          // Saturate so a long stall cannot wrap back below TIMEOUT.
          if (wait_cnt_r != TIMEOUT_C) begin
            wait_cnt_nxt_s = wait_cnt_r + CW'(1);
          end else begin
            wait_cnt_nxt_s = wait_cnt_r;
          end
          timeout_hit_s = (wait_cnt_nxt_s == TIMEOUT_C);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      wait_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Registered send interface: s_data loads only on a pop, so it holds while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_en_r   <= 1'b0;
      s_data_r <= '0;
    end else begin
      s_en_r <= pop_s;
      if (pop_s) begin
        s_data_r <= fifo_dout_s;
      end
    end
  end

  // Sticky error flags and the acknowledged-transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err_r  <= 1'b0;
      spurious_ack_r <= 1'b0;
      sent_count_r   <= 16'd0;
    end else begin
      timeout_err_r  <= timeout_err_r | timeout_hit_s;
      spurious_ack_r <= spurious_ack_r | spurious_s;
      if (ack_ok_s) begin
        sent_count_r <= sent_count_r + 16'd1;
      end
    end
  end

  assign s_en         = s_en_r;
  assign s_data       = s_data_r;
  assign busy         = (state_r == WAIT_ACK);
  assign timeout_err  = timeout_err_r;
  assign spurious_ack = spurious_ack_r;
  assign sent_count   = sent_count_r;

endmodule
